// File: rtl/sisc_fetch_pkg.sv
// Shared definitions for the SISC instruction-fetch front end.
package sisc_fetch_pkg;

    localparam int          SISC_AW       = 16;
    localparam int          SISC_DW       = 32;
    localparam logic [15:0] SISC_RESET_PC = 16'h0000;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sisc_fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of W bits, synchronous flush, head entry read
// straight out of the storage registers.
module sisc_fetch_fifo #(
    parameter  int W     = 48,
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    // Pointer and occupancy update; flush discards everything, including a concurrent pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; not reset because contents are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push)
            r_mem[r_wr] <= wdata;
    end

    assign rdata = r_mem[r_rd];
    assign count = r_count;

endmodule

// File: rtl/sisc_fetch.sv
// SISC fetch front end: PC register, FETCH/HALTED control, redirect handling
// and a small prefetch FIFO feeding decode over valid/ready.
module sisc_fetch
    import sisc_fetch_pkg::*;
#(
    parameter  int          AW       = SISC_AW,
    parameter  int          DW       = SISC_DW,
    parameter  int          DEPTH    = 2,
    parameter  logic [AW-1:0] RESET_PC = AW'(SISC_RESET_PC),
    localparam int          CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] im_addr,
    input  logic [DW-1:0] im_data,
    input  logic          br_taken,
    input  logic [AW-1:0] br_addr,
    input  logic          halt,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [DW-1:0] ir_data,
    output logic [AW-1:0] ir_pc,
    output logic          halted
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [AW-1:0]    r_pc;
    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_pop;
    logic [AW+DW-1:0] w_head;

    // Halt always wins; a redirect without halt is the only way back to fetching.
    always_comb begin
        w_state_nxt = r_state;
        if (halt)
            w_state_nxt = ST_HALTED;
        else if (br_taken)
            w_state_nxt = ST_FETCH;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_state_nxt;
    end

    // No pass-through when full: the count check ignores a same-cycle pop.
    assign w_push = (r_state == ST_FETCH) && !halt && !br_taken && (w_count < CW'(DEPTH));
    assign w_pop  = ir_valid && ir_ready && !br_taken;

    // PC: redirect loads the target, a push advances to the next word (wraps naturally).
    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= RESET_PC;
        else if (br_taken)
            r_pc <= br_addr;
        else if (w_push)
            r_pc <= r_pc + 1'b1;
    end

    sisc_fetch_fifo #(.W(AW + DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (br_taken),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({r_pc, im_data}),
        .rdata (w_head),
        .count (w_count)
    );

    assign im_addr  = r_pc;
    assign ir_valid = (w_count != '0);
    assign ir_pc    = w_head[AW+DW-1:DW];
    assign ir_data  = w_head[DW-1:0];
    assign halted   = (r_state == ST_HALTED) && (w_count == '0);

endmodule

// File: tb/tb_sisc_fetch.sv
// Self-checking bench for sisc_fetch: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_sisc_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic        br_taken;
    logic [15:0] br_addr;
    logic        halt;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic [15:0] ir_pc;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] m_pc;
    bit          m_halt;

    always #5 clk = ~clk;

    // Instruction memory image: instr = A000_0000 | addr.
    assign im_data = 32'hA000_0000 | {16'h0, im_addr};

    sisc_fetch #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .im_addr  (im_addr),
        .im_data  (im_data),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .halt     (halt),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .ir_data  (ir_data),
        .ir_pc    (ir_pc),
        .halted   (halted)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: advance one clock edge given the inputs for that cycle.
    task automatic model_step(input bit r, input bit b, input logic [15:0] ba,
                              input bit h, input bit rdy);
        bit do_pop, do_push;
        if (r) begin
            m_pc = 16'h0000; m_q.delete(); m_halt = 0;
        end else if (b) begin
            m_q.delete(); m_pc = ba; m_halt = h;
        end else begin
            do_pop  = (m_q.size() != 0) && rdy;
            do_push = !m_halt && !h && (m_q.size() < DEPTH);
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back('{pc: m_pc, ins: 32'hA000_0000 | {16'h0, m_pc}});
                m_pc = m_pc + 16'h1;
            end
            if (h) m_halt = 1;
        end
    endtask

    task automatic compare();
        chk("im_addr", im_addr, m_pc);
        chk("ir_valid", ir_valid, m_q.size() != 0);
        chk("halted", halted, m_halt && (m_q.size() == 0));
        if (m_q.size() != 0) begin
            chk("ir_pc", ir_pc, m_q[0].pc);
            chk("ir_data", ir_data, m_q[0].ins);
        end
    endtask

    // One cycle: drive at negedge, clock, sample at the following negedge.
    task automatic cyc(input bit r, input bit b, input logic [15:0] ba,
                       input bit h, input bit rdy);
        rst = r; br_taken = b; br_addr = ba; halt = h; ir_ready = rdy;
        model_step(r, b, ba, h, rdy);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        rst = 1; br_taken = 0; br_addr = '0; halt = 0; ir_ready = 0;
        m_pc = 0; m_halt = 0;
        @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_addr", im_addr, 16'h0000);
        chk("rst_halted", halted, 0);

        // 1: free run with ready high
        cyc(0, 0, 0, 0, 1);
        chk("s1_first_valid", ir_valid, 1);
        chk("s1_first_pc", ir_pc, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("s1_seq_pc", ir_pc, 16'(i + 1));
        end

        // 2: backpressure; restart from reset so ir_pc sits at 0
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        chk("s2_stall_pc", im_addr, 16'h0002);
        chk("s2_stall_irpc", ir_pc, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("s2_drain_pc", ir_pc, 16'(i + 1));
        end

        // 3: redirect with a full FIFO
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 16'h0040, 0, 1);
        chk("s3_bubble_valid", ir_valid, 0);
        chk("s3_bubble_addr", im_addr, 16'h0040);
        cyc(0, 0, 0, 0, 0);
        chk("s3_tgt_pc", ir_pc, 16'h0040);
        chk("s3_tgt_data", ir_data, 32'hA000_0040);

        // 4: PC wrap
        cyc(0, 1, 16'hFFFE, 0, 1);
        cyc(0, 0, 0, 0, 1); chk("s4_w0", ir_pc, 16'hFFFE);
        cyc(0, 0, 0, 0, 1); chk("s4_w1", ir_pc, 16'hFFFF);
        cyc(0, 0, 0, 0, 1); chk("s4_w2", ir_pc, 16'h0000);
        cyc(0, 0, 0, 0, 1); chk("s4_w3", ir_pc, 16'h0001);

        // 5: halt with two entries queued, drain, then redirect out
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("s5_not_yet", halted, 0);
        cyc(0, 0, 0, 0, 1);
        chk("s5_one_left", halted, 0);
        cyc(0, 0, 0, 0, 1);
        chk("s5_halted", halted, 1);
        cyc(0, 0, 0, 0, 1);
        chk("s5_frozen", halted, 1);
        cyc(0, 1, 16'h0010, 0, 1);
        chk("s5_resume_halted", halted, 0);
        chk("s5_resume_addr", im_addr, 16'h0010);
        cyc(0, 0, 0, 0, 1);
        chk("s5_resume_pc", ir_pc, 16'h0010);

        // 6: reset mid-stream overrides branch and halt
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 16'h0123, 1, 1);
        chk("s6_valid", ir_valid, 0);
        chk("s6_addr", im_addr, 16'h0000);
        chk("s6_halted", halted, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 39) == 0,
                $urandom_range(0, 9) == 0,
                16'($urandom),
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
